// File: rtl/csr_hpm_counters_pkg.sv
// Shared CSR definitions for the hardware performance monitor block:
// address map constants, funct3 operation encodings, mcountinhibit bit
// positions, the address decode result type and a decode helper.
package csr_hpm_counters_pkg;

   // Address map
   localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
   localparam logic [11:0] CSR_MHPMEVENT_BASE = 12'h320;
   localparam logic [11:0] CSR_MCOUNTER_LO    = 12'hB00;
   localparam logic [11:0] CSR_MCOUNTER_HI    = 12'hB80;
   localparam logic [11:0] CSR_COUNTER_LO     = 12'hC00;
   localparam logic [11:0] CSR_COUNTER_HI     = 12'hC80;

   // funct3 encodings: bit 2 selects the immediate operand
   localparam int         OP_IMM_BIT = 2;
   localparam logic [1:0] OP_RW      = 2'b01;
   localparam logic [1:0] OP_RS      = 2'b10;
   localparam logic [1:0] OP_RC      = 2'b11;

   // mcountinhibit bit positions (bit 1, time, is hardwired to 0)
   localparam int INH_CY       = 0;
   localparam int INH_TM       = 1;
   localparam int INH_IR       = 2;
   localparam int INH_HPM_BASE = 3;

   typedef enum logic [1:0] {
      CSR_NONE,
      CSR_INHIBIT,
      CSR_EVENT,
      CSR_COUNTER
   } csr_kind_e;

   // idx: hpm number (0 = mhpmevent3) for CSR_EVENT,
   //      counter slot (0 cycle, 1 instret, 2+i hpm i+3) for CSR_COUNTER
   typedef struct packed {
      csr_kind_e  kind;
      logic       hi;
      logic [4:0] idx;
   } csr_dec_t;

   function automatic csr_dec_t csr_decode(input logic [11:0] addr, input int num_hpm);
      csr_dec_t   d;
      logic [4:0] n;
      d.kind = CSR_NONE;
      d.hi   = 1'b0;
      d.idx  = '0;
      n      = addr[4:0];
      if (addr == CSR_MCOUNTINHIBIT) begin
         d.kind = CSR_INHIBIT;
      end else if (addr[11:5] == CSR_MHPMEVENT_BASE[11:5]) begin
         if (int'(n) >= 3 && int'(n) < num_hpm + 3) begin
            d.kind = CSR_EVENT;
            d.idx  = n - 5'd3;
         end
      end else if ((addr[11:8] == CSR_MCOUNTER_LO[11:8] || addr[11:8] == CSR_COUNTER_LO[11:8])
                   && addr[6:5] == 2'b00) begin
         // 0xB00/0xB80/0xC00/0xC80 windows; bit 7 picks the high half
         d.hi = addr[7];
         if (n == 5'd0) begin
            d.kind = CSR_COUNTER;
            d.idx  = 5'd0;
         end else if (n == 5'd2) begin
            d.kind = CSR_COUNTER;
            d.idx  = 5'd1;
         end else if (int'(n) >= 3 && int'(n) < num_hpm + 3) begin
            d.kind = CSR_COUNTER;
            d.idx  = n - 5'd1;
         end
      end
      return d;
   endfunction

   function automatic logic [31:0] inhibit_mask(input int num_hpm);
      logic [31:0] m;
      m         = '0;
      m[INH_CY] = 1'b1;
      m[INH_IR] = 1'b1;
      for (int i = 0; i < num_hpm; i++) begin
         m[INH_HPM_BASE + i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/csr_hpm_counters_slice.sv
// One performance counter of CNT_WIDTH bits with increment enable,
// separate low/high write ports and a sticky wrap flag.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc_en      count up by one this cycle
//   wr_lo/wr_hi load wdata into bits [31:0] / [CNT_WIDTH-1:32]
//   wdata       32-bit write data
//   cnt         counter value
//   ovf         set on wrap from all-ones, cleared by any write
module hpm_counter_slice
   import csr_hpm_counters_pkg::*;
#(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc_en,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wdata,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 ovf
);

   localparam int HI_W = CNT_WIDTH - 32;

   // A write always wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (wr_lo) begin
         cnt <= {cnt[CNT_WIDTH-1:32], wdata};
      end else if (wr_hi) begin
         cnt <= {wdata[HI_W-1:0], cnt[31:0]};
      end else if (inc_en) begin
         cnt <= cnt + CNT_WIDTH'(1);
      end
   end

   // Clearing by a write takes priority over a coincident wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (wr_lo || wr_hi) begin
         ovf <= 1'b0;
      end else if (inc_en && (&cnt)) begin
         ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/csr_hpm_counters.sv
// Machine performance counters: mcycle, minstret, NUM_HPM mhpmcounters with
// their mhpmevent selectors, and mcountinhibit. Accessible by CSR
// instructions in EX and by a debug monitor port.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cmd_csr_ex, csr_ofs_ex,
//   csr_op2_ex, csr_uimm_ex,
//   rs1_sel, stall              CSR instruction in EX
//   retire, event_in            counting conditions
//   csr_rd_data, csr_hit        read data / decode hit for selected address
//   hpm_ovf                     sticky wrap flags per counter
//   csr_radr_en_mon, ...        monitor read/write port
//   csr_rdata_mon               monitor read data (same as csr_rd_data)
module csr_hpm_counters
   import csr_hpm_counters_pkg::*;
#(
   parameter int NUM_HPM   = 4,
   parameter int CNT_WIDTH = 64,
   parameter int NUM_EVT   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_csr_ex,
   input  logic [11:0]          csr_ofs_ex,
   input  logic [2:0]           csr_op2_ex,
   input  logic [4:0]           csr_uimm_ex,
   input  logic [31:0]          rs1_sel,
   input  logic                 stall,
   input  logic                 retire,
   input  logic [NUM_EVT-1:0]   event_in,
   output logic [31:0]          csr_rd_data,
   output logic                 csr_hit,
   output logic [NUM_HPM+1:0]   hpm_ovf,
   input  logic                 csr_radr_en_mon,
   input  logic [11:0]          csr_radr_mon,
   input  logic                 csr_we_mon,
   input  logic [11:0]          csr_wadr_mon,
   input  logic [31:0]          csr_wdata_mon,
   output logic [31:0]          csr_rdata_mon
);

   localparam int          NCNT     = NUM_HPM + 2;
   localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

   logic [NCNT*CNT_WIDTH-1:0] cnt_flat;
   logic [NUM_HPM*5-1:0]      evt_flat;
   logic [31:0]               inhibit;

   logic [11:0] sel_addr;
   csr_dec_t    sel_dec;
   csr_dec_t    ex_dec;
   csr_dec_t    mon_dec;
   csr_dec_t    wr_dec;
   logic        ex_ro;
   logic [31:0] sel_rdata;
   logic [31:0] operand;
   logic [31:0] ex_cur;
   logic [31:0] ex_wdata;
   logic [31:0] wdata;
   logic        ex_we;
   logic        mon_we;
   logic        wr_en;
   logic [NUM_HPM-1:0] evt_hit;
   logic [NCNT-1:0]    cond;

   function automatic logic [31:0] read_val(
      input csr_dec_t                  d,
      input logic [NCNT*CNT_WIDTH-1:0] cnts,
      input logic [NUM_HPM*5-1:0]      evts,
      input logic [31:0]               inh
   );
      logic [31:0]          v;
      logic [CNT_WIDTH-1:0] c_val;
      v     = '0;
      c_val = '0;
      case (d.kind)
         CSR_INHIBIT: v = inh;
         CSR_EVENT: begin
            for (int i = 0; i < NUM_HPM; i++) begin
               if (d.idx == 5'(i)) v = {27'd0, evts[i*5 +: 5]};
            end
         end
         CSR_COUNTER: begin
            for (int c = 0; c < NCNT; c++) begin
               if (d.idx == 5'(c)) c_val = cnts[c*CNT_WIDTH +: CNT_WIDTH];
            end
            v = d.hi ? 32'(c_val[CNT_WIDTH-1:32]) : c_val[31:0];
         end
         default: v = '0;
      endcase
      return v;
   endfunction

   // Read address priority: monitor read, monitor write, instruction
   always_comb begin
      sel_addr = csr_ofs_ex;
      if (csr_radr_en_mon) begin
         sel_addr = csr_radr_mon;
      end else if (csr_we_mon) begin
         sel_addr = csr_wadr_mon;
      end
   end

   assign sel_dec       = csr_decode(sel_addr, NUM_HPM);
   assign ex_dec        = csr_decode(csr_ofs_ex, NUM_HPM);
   assign mon_dec       = csr_decode(csr_wadr_mon, NUM_HPM);
   assign ex_ro         = (csr_ofs_ex[11:8] == CSR_COUNTER_LO[11:8]);
   assign sel_rdata     = read_val(sel_dec, cnt_flat, evt_flat, inhibit);
   assign csr_rd_data   = sel_rdata;
   assign csr_rdata_mon = sel_rdata;
   assign csr_hit       = (sel_dec.kind != CSR_NONE);

   // The instruction's read-modify-write uses its own address, independent
   // of whatever the monitor is reading this cycle.
   always_comb begin
      operand  = csr_op2_ex[OP_IMM_BIT] ? {27'd0, csr_uimm_ex} : rs1_sel;
      ex_cur   = read_val(ex_dec, cnt_flat, evt_flat, inhibit);
      ex_wdata = operand;
      case (csr_op2_ex[1:0])
         OP_RW:   ex_wdata = operand;
         OP_RS:   ex_wdata = operand | ex_cur;
         OP_RC:   ex_wdata = ~operand & ex_cur;
         default: ex_wdata = operand;
      endcase
   end

   always_comb begin
      ex_we  = cmd_csr_ex && !stall && (ex_dec.kind != CSR_NONE) && !ex_ro
               && (csr_op2_ex[1:0] != 2'b00);
      mon_we = csr_we_mon && !ex_we && (mon_dec.kind != CSR_NONE);
      wr_en  = ex_we || mon_we;
      wr_dec = ex_we ? ex_dec : mon_dec;
      wdata  = ex_we ? ex_wdata : csr_wdata_mon;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inhibit <= '0;
      end else if (wr_en && wr_dec.kind == CSR_INHIBIT) begin
         inhibit <= wdata & INH_MASK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_flat <= '0;
      end else begin
         for (int i = 0; i < NUM_HPM; i++) begin
            if (wr_en && wr_dec.kind == CSR_EVENT && wr_dec.idx == 5'(i)) begin
               evt_flat[i*5 +: 5] <= wdata[4:0];
            end
         end
      end
   end

   // Selector 0 or beyond NUM_EVT matches no event bit, so never counts
   always_comb begin
      evt_hit = '0;
      for (int i = 0; i < NUM_HPM; i++) begin
         for (int k = 0; k < NUM_EVT; k++) begin
            if (evt_flat[i*5 +: 5] == 5'(k + 1) && event_in[k]) evt_hit[i] = 1'b1;
         end
      end
   end

   assign cond = {evt_hit, retire, 1'b1};

   for (genvar c = 0; c < NCNT; c++) begin : g_cnt
      localparam int INH_BIT = (c == 0) ? INH_CY : ((c == 1) ? INH_IR : INH_HPM_BASE + c - 2);
      logic inc_en;
      logic wr_lo;
      logic wr_hi;

      assign inc_en = cond[c] && !inhibit[INH_BIT];
      assign wr_lo  = wr_en && wr_dec.kind == CSR_COUNTER && wr_dec.idx == 5'(c) && !wr_dec.hi;
      assign wr_hi  = wr_en && wr_dec.kind == CSR_COUNTER && wr_dec.idx == 5'(c) && wr_dec.hi;

      hpm_counter_slice #(
         .CNT_WIDTH(CNT_WIDTH)
      ) u_slice (
         .clk   (clk),
         .rst_n (rst_n),
         .inc_en(inc_en),
         .wr_lo (wr_lo),
         .wr_hi (wr_hi),
         .wdata (wdata),
         .cnt   (cnt_flat[c*CNT_WIDTH +: CNT_WIDTH]),
         .ovf   (hpm_ovf[c])
      );
   end

endmodule

// File: tb/tb_csr_hpm_counters.sv
module tb_csr_hpm_counters;

   logic        clk;
   logic        rst_n;
   logic        cmd_csr_ex;
   logic [11:0] csr_ofs_ex;
   logic [2:0]  csr_op2_ex;
   logic [4:0]  csr_uimm_ex;
   logic [31:0] rs1_sel;
   logic        stall;
   logic        retire;
   logic [7:0]  event_in;
   logic [31:0] csr_rd_data;
   logic        csr_hit;
   logic [5:0]  hpm_ovf;
   logic        csr_radr_en_mon;
   logic [11:0] csr_radr_mon;
   logic        csr_we_mon;
   logic [11:0] csr_wadr_mon;
   logic [31:0] csr_wdata_mon;
   logic [31:0] csr_rdata_mon;

   int nvec = 0;
   int nerr = 0;

   localparam logic [2:0] RW  = 3'b001;
   localparam logic [2:0] RS  = 3'b010;
   localparam logic [2:0] RCI = 3'b111;

   csr_hpm_counters #(.NUM_HPM(4), .CNT_WIDTH(64), .NUM_EVT(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_csr_ex     (cmd_csr_ex),
      .csr_ofs_ex     (csr_ofs_ex),
      .csr_op2_ex     (csr_op2_ex),
      .csr_uimm_ex    (csr_uimm_ex),
      .rs1_sel        (rs1_sel),
      .stall          (stall),
      .retire         (retire),
      .event_in       (event_in),
      .csr_rd_data    (csr_rd_data),
      .csr_hit        (csr_hit),
      .hpm_ovf        (hpm_ovf),
      .csr_radr_en_mon(csr_radr_en_mon),
      .csr_radr_mon   (csr_radr_mon),
      .csr_we_mon     (csr_we_mon),
      .csr_wadr_mon   (csr_wadr_mon),
      .csr_wdata_mon  (csr_wdata_mon),
      .csr_rdata_mon  (csr_rdata_mon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, need finished");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic h);
      csr_radr_en_mon = 1'b1;
      csr_radr_mon    = a;
      #1;
      d = csr_rdata_mon;
      h = csr_hit;
      csr_radr_en_mon = 1'b0;
   endtask

   task automatic do_instr(input logic [11:0] a, input logic [2:0] op,
                           input logic [31:0] r, input logic [4:0] u, input logic stl);
      cmd_csr_ex  = 1'b1;
      csr_ofs_ex  = a;
      csr_op2_ex  = op;
      rs1_sel     = r;
      csr_uimm_ex = u;
      stall       = stl;
      tick(1);
      cmd_csr_ex  = 1'b0;
      stall       = 1'b0;
   endtask

   task automatic mon_wr(input logic [11:0] a, input logic [31:0] d);
      csr_we_mon    = 1'b1;
      csr_wadr_mon  = a;
      csr_wdata_mon = d;
      tick(1);
      csr_we_mon    = 1'b0;
   endtask

   task automatic test_reset;
      csr_ofs_ex = 12'hB00;
      #2;
      nvec++;
      if (csr_rd_data !== 32'd0 || csr_hit !== 1'b1) begin
         $display("FAIL reset_read_b00: got data=%h hit=%b, need data=0 hit=1", csr_rd_data, csr_hit);
         nerr++;
      end
      nvec++;
      if (hpm_ovf !== 6'd0) begin
         $display("FAIL reset_ovf: got %b, need 000000", hpm_ovf);
         nerr++;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_idle_count;
      logic [31:0] d;
      logic        h;
      tick(10);
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'd10) begin
         $display("FAIL idle_mcycle: got %0d, need 10", d);
         nerr++;
      end
      rd(12'hB02, d, h);
      nvec++;
      if (d !== 32'd0 || h !== 1'b1) begin
         $display("FAIL idle_minstret: got %h hit=%b, need 0 hit=1", d, h);
         nerr++;
      end
   endtask

   task automatic test_wrap;
      logic [31:0] d;
      logic        h;
      do_instr(12'hB00, RW, 32'hFFFF_FFFF, 5'd0, 1'b0);
      do_instr(12'hB80, RW, 32'hFFFF_FFFF, 5'd0, 1'b0);
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'hFFFF_FFFF || hpm_ovf[0] !== 1'b0) begin
         $display("FAIL wrap_preload: got %h ovf=%b, need ffffffff ovf=0", d, hpm_ovf[0]);
         nerr++;
      end
      tick(1);
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'd0 || hpm_ovf[0] !== 1'b1) begin
         $display("FAIL wrap_lo: got %h ovf=%b, need 0 ovf=1", d, hpm_ovf[0]);
         nerr++;
      end
      rd(12'hC80, d, h);
      nvec++;
      if (d !== 32'd0) begin
         $display("FAIL wrap_hi: got %h, need 0", d);
         nerr++;
      end
      tick(2);
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'd2 || hpm_ovf[0] !== 1'b1) begin
         $display("FAIL wrap_sticky: got %h ovf=%b, need 2 ovf=1", d, hpm_ovf[0]);
         nerr++;
      end
      do_instr(12'hB00, RW, 32'd0, 5'd0, 1'b0);
      nvec++;
      if (hpm_ovf[0] !== 1'b0) begin
         $display("FAIL wrap_clear: got ovf=%b, need 0", hpm_ovf[0]);
         nerr++;
      end
   endtask

   task automatic test_events;
      logic [31:0] d;
      logic        h;
      do_instr(12'h323, RW, 32'd2, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         event_in = 8'h02;
         tick(1);
         event_in = 8'h00;
         tick(1);
      end
      for (int i = 0; i < 3; i++) begin
         event_in = 8'h01;
         tick(1);
         event_in = 8'h00;
         tick(1);
      end
      rd(12'hB03, d, h);
      nvec++;
      if (d !== 32'd5) begin
         $display("FAIL event_count: got %0d, need 5", d);
         nerr++;
      end
      rd(12'hC03, d, h);
      nvec++;
      if (d !== 32'd5 || h !== 1'b1) begin
         $display("FAIL event_shadow: got %0d hit=%b, need 5 hit=1", d, h);
         nerr++;
      end
      rd(12'hB04, d, h);
      nvec++;
      if (d !== 32'd0) begin
         $display("FAIL event_sel0: got %0d, need 0", d);
         nerr++;
      end
      do_instr(12'h323, RW, 32'd9, 5'd0, 1'b0);
      rd(12'h323, d, h);
      nvec++;
      if (d !== 32'd9) begin
         $display("FAIL event_sel_read: got %0d, need 9", d);
         nerr++;
      end
      for (int i = 0; i < 3; i++) begin
         event_in = 8'hFF;
         tick(1);
      end
      event_in = 8'h00;
      rd(12'hB03, d, h);
      nvec++;
      if (d !== 32'd5) begin
         $display("FAIL event_out_of_range: got %0d, need 5", d);
         nerr++;
      end
      do_instr(12'h323, RW, 32'hFFFF_FFFF, 5'd0, 1'b0);
      rd(12'h323, d, h);
      nvec++;
      if (d !== 32'h1F) begin
         $display("FAIL event_5bit: got %h, need 1f", d);
         nerr++;
      end
   endtask

   task automatic test_inhibit;
      logic [31:0] d;
      logic        h;
      do_instr(12'hB00, RW, 32'h1000, 5'd0, 1'b0);
      do_instr(12'hB02, RW, 32'd0, 5'd0, 1'b0);
      do_instr(12'h320, RS, 32'd5, 5'd0, 1'b0);
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'h1002) begin
         $display("FAIL inh_write_cycle: got %h, need 1002", d);
         nerr++;
      end
      retire = 1'b1;
      tick(3);
      retire = 1'b0;
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'h1002) begin
         $display("FAIL inh_mcycle_frozen: got %h, need 1002", d);
         nerr++;
      end
      rd(12'hB02, d, h);
      nvec++;
      if (d !== 32'd0) begin
         $display("FAIL inh_minstret_frozen: got %h, need 0", d);
         nerr++;
      end
      rd(12'h320, d, h);
      nvec++;
      if (d !== 32'd5 || h !== 1'b1) begin
         $display("FAIL inh_read: got %h hit=%b, need 5 hit=1", d, h);
         nerr++;
      end
      do_instr(12'h320, RCI, 32'd0, 5'd5, 1'b0);
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'h1002) begin
         $display("FAIL inh_clear_delay: got %h, need 1002", d);
         nerr++;
      end
      retire = 1'b1;
      tick(3);
      retire = 1'b0;
      rd(12'hB02, d, h);
      nvec++;
      if (d !== 32'd3) begin
         $display("FAIL inh_resume_minstret: got %h, need 3", d);
         nerr++;
      end
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'h1005) begin
         $display("FAIL inh_resume_mcycle: got %h, need 1005", d);
         nerr++;
      end
      do_instr(12'h320, RW, 32'hFFFF_FFFF, 5'd0, 1'b0);
      rd(12'h320, d, h);
      nvec++;
      if (d !== 32'h7D) begin
         $display("FAIL inh_mask: got %h, need 7d", d);
         nerr++;
      end
      do_instr(12'h320, RW, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic test_instr_write;
      logic [31:0] d;
      logic        h;
      do_instr(12'hB02, RW, 32'h1234, 5'd0, 1'b1);
      rd(12'hB02, d, h);
      nvec++;
      if (d !== 32'd3) begin
         $display("FAIL stall_blocks: got %h, need 3", d);
         nerr++;
      end
      retire = 1'b1;
      do_instr(12'hB02, RW, 32'h100, 5'd0, 1'b0);
      retire = 1'b0;
      rd(12'hB02, d, h);
      nvec++;
      if (d !== 32'h100) begin
         $display("FAIL write_beats_retire: got %h, need 100", d);
         nerr++;
      end
      do_instr(12'hC02, RW, 32'h55, 5'd0, 1'b0);
      rd(12'hB02, d, h);
      nvec++;
      if (d !== 32'h100) begin
         $display("FAIL shadow_write_ignored: got %h, need 100", d);
         nerr++;
      end
   endtask

   task automatic test_monitor;
      logic [31:0] d;
      logic        h;
      csr_we_mon    = 1'b1;
      csr_wadr_mon  = 12'hB83;
      csr_wdata_mon = 32'hAAAA;
      do_instr(12'hB03, RW, 32'h77, 5'd0, 1'b0);
      csr_we_mon    = 1'b0;
      rd(12'hB03, d, h);
      nvec++;
      if (d !== 32'h77) begin
         $display("FAIL collide_instr: got %h, need 77", d);
         nerr++;
      end
      rd(12'hB83, d, h);
      nvec++;
      if (d !== 32'd0) begin
         $display("FAIL collide_mon_dropped: got %h, need 0", d);
         nerr++;
      end
      mon_wr(12'hB83, 32'h12);
      rd(12'hB83, d, h);
      nvec++;
      if (d !== 32'h12) begin
         $display("FAIL mon_write_hi: got %h, need 12", d);
         nerr++;
      end
      mon_wr(12'hC03, 32'h99);
      rd(12'hB03, d, h);
      nvec++;
      if (d !== 32'h99) begin
         $display("FAIL mon_write_shadow: got %h, need 99", d);
         nerr++;
      end
      rd(12'h7FF, d, h);
      nvec++;
      if (d !== 32'd0 || h !== 1'b0) begin
         $display("FAIL unmapped_7ff: got %h hit=%b, need 0 hit=0", d, h);
         nerr++;
      end
      rd(12'hB01, d, h);
      nvec++;
      if (d !== 32'd0 || h !== 1'b0) begin
         $display("FAIL unmapped_time: got %h hit=%b, need 0 hit=0", d, h);
         nerr++;
      end
      csr_ofs_ex = 12'hB03;
      #1;
      nvec++;
      if (csr_rd_data !== 32'h99 || csr_hit !== 1'b1) begin
         $display("FAIL ex_read_path: got %h hit=%b, need 99 hit=1", csr_rd_data, csr_hit);
         nerr++;
      end
   endtask

   task automatic test_reset_midcount;
      logic [31:0] d;
      logic        h;
      rst_n = 1'b0;
      #1;
      rd(12'hB00, d, h);
      nvec++;
      if (d !== 32'd0) begin
         $display("FAIL midreset_mcycle: got %h, need 0", d);
         nerr++;
      end
      rd(12'hB83, d, h);
      nvec++;
      if (d !== 32'd0 || hpm_ovf !== 6'd0) begin
         $display("FAIL midreset_hi: got %h ovf=%b, need 0 ovf=0", d, hpm_ovf);
         nerr++;
      end
      tick(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n           = 1'b0;
      cmd_csr_ex      = 1'b0;
      csr_ofs_ex      = 12'h000;
      csr_op2_ex      = 3'b000;
      csr_uimm_ex     = 5'd0;
      rs1_sel         = 32'd0;
      stall           = 1'b0;
      retire          = 1'b0;
      event_in        = 8'h00;
      csr_radr_en_mon = 1'b0;
      csr_radr_mon    = 12'h000;
      csr_we_mon      = 1'b0;
      csr_wadr_mon    = 12'h000;
      csr_wdata_mon   = 32'd0;

      test_reset();
      test_idle_count();
      test_wrap();
      test_events();
      test_inhibit();
      test_instr_write();
      test_monitor();
      test_reset_midcount();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
